// File: rtl/irq_collector8_pkg.sv
// Shared constants and FSM encoding for the eight-channel request collector.
package irq_collector8_pkg;

    localparam int N_CH = 8;
    localparam int ID_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

endpackage

// File: rtl/irq_collector8_prio_enc8.sv
// Lowest-index-first priority encoder: returns the smallest set bit position and an any flag.
module prio_enc8
    import irq_collector8_pkg::*;
(
    input  logic [N_CH-1:0] vec,
    output logic [ID_W-1:0] id,
    output logic            any
);

    always_comb begin
        id  = '0;
        any = |vec;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_collector8.sv
// Sticky eight-channel request collector with enable mask, overflow flags and a
// lowest-index-first valid/ready grant serialiser.
module irq_collector8
    import irq_collector8_pkg::*;
#(
    parameter logic [7:0] MASK_RST = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       mask_we,
    input  logic [7:0] mask_in,
    output logic [7:0] pend,
    output logic [7:0] raw_pend,
    output logic       out_valid,
    output logic [2:0] out_id,
    input  logic       out_ready,
    output logic [7:0] ovf,
    input  logic [7:0] ovf_clr
);

    logic [N_CH-1:0] raw_pend_q, raw_pend_d;
    logic [N_CH-1:0] ovf_q, ovf_d;
    logic [N_CH-1:0] mask_q, mask_d;
    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [ID_W-1:0] out_id_q, out_id_d;

    logic            accept;
    logic [N_CH-1:0] acc_vec;
    logic [N_CH-1:0] pend_w;
    logic [ID_W-1:0] enc_id;
    logic            enc_any;

    assign pend_w = raw_pend_q & mask_q;

    prio_enc8 u_prio_enc8 (
        .vec (pend_w),
        .id  (enc_id),
        .any (enc_any)
    );

    always_comb begin
        accept  = out_valid_q & out_ready;
        acc_vec = '0;
        if (accept) begin
            acc_vec[out_id_q] = 1'b1;
        end

        // A request on the accept edge re-pends the channel and is not an overflow.
        raw_pend_d = req | (raw_pend_q & ~acc_vec);
        ovf_d      = (req & raw_pend_q & ~acc_vec) | (ovf_q & ~ovf_clr);
        mask_d     = mask_we ? mask_in : mask_q;

        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    state_d     = OFFER;
                    out_valid_d = 1'b1;
                    out_id_d    = enc_id;
                end
            end
            OFFER: begin
                // Offer stays frozen until taken, regardless of new requests or mask edits.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_pend_q  <= '0;
            ovf_q       <= '0;
            mask_q      <= MASK_RST;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
        end else begin
            raw_pend_q  <= raw_pend_d;
            ovf_q       <= ovf_d;
            mask_q      <= mask_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
        end
    end

    assign pend      = pend_w;
    assign raw_pend  = raw_pend_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_irq_collector8.sv
// Scoreboard bench for irq_collector8: directed request patterns, grant order via queue.
module tb_irq_collector8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_in;
    logic [7:0] pend;
    logic [7:0] raw_pend;
    logic       out_valid;
    logic [2:0] out_id;
    logic       out_ready;
    logic [7:0] ovf;
    logic [7:0] ovf_clr;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    irq_collector8 #(.MASK_RST(8'hFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mask_we   (mask_we),
        .mask_in   (mask_in),
        .pend      (pend),
        .raw_pend  (raw_pend),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_ready (out_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake that will complete at the next edge must match the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected: got id %0d expected none", out_id);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (out_id !== e) begin
                    errors++;
                    $display("FAIL grant_id: got %0d expected %0d", out_id, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; req = 8'hFF; mask_we = 1'b0; mask_in = 8'h00;
        out_ready = 1'b0; ovf_clr = 8'h00;
        #1;
        tick(); tick();
        chk("rst_raw_pend", raw_pend, 8'h00);
        chk("rst_pend", pend, 8'h00);
        chk("rst_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_ovf", ovf, 8'h00);
        chk("rst_id", {5'd0, out_id}, 8'h00);
        reset = 1'b0; req = 8'h00;
        tick(); tick();
        chk("idle_raw_pend", raw_pend, 8'h00);
        chk("idle_valid", {7'd0, out_valid}, 8'h00);

        // Two channels, continuous ready: ids 2 then 5.
        req = 8'h24; out_ready = 1'b1;
        exp_q.push_back(3'd2); exp_q.push_back(3'd5);
        tick();
        req = 8'h00;
        chk("two_pend", pend, 8'h24);
        chk("two_valid_lat", {7'd0, out_valid}, 8'h00);
        tick();
        chk("two_first_valid", {7'd0, out_valid}, 8'h01);
        chk("two_first_id", {5'd0, out_id}, 8'h02);
        tick();
        chk("two_gap_valid", {7'd0, out_valid}, 8'h00);
        chk("two_after_first", raw_pend, 8'h20);
        tick();
        chk("two_second_id", {5'd0, out_id}, 8'h05);
        tick();
        chk("two_done_pend", pend, 8'h00);
        chk("two_done_valid", {7'd0, out_valid}, 8'h00);
        tick();

        // Held offer: lower index arriving later must not displace id 6.
        out_ready = 1'b0; req = 8'h40;
        tick();
        req = 8'h00;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("hold_id", {5'd0, out_id}, 8'h06);
            tick();
        end
        req = 8'h02;
        tick();
        req = 8'h00;
        chk("hold_id_after_low", {5'd0, out_id}, 8'h06);
        chk("hold_valid", {7'd0, out_valid}, 8'h01);
        chk("hold_raw", raw_pend, 8'h42);
        exp_q.push_back(3'd6); exp_q.push_back(3'd1);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("hold_done", raw_pend, 8'h00);

        // Mask off low nibble: requests latch but are never offered.
        mask_in = 8'hF0; mask_we = 1'b1;
        tick();
        mask_we = 1'b0; req = 8'h0F;
        tick();
        req = 8'h00;
        chk("mask_raw", raw_pend, 8'h0F);
        chk("mask_pend", pend, 8'h00);
        tick(); tick();
        chk("mask_no_offer", {7'd0, out_valid}, 8'h00);
        exp_q.push_back(3'd0); exp_q.push_back(3'd1);
        exp_q.push_back(3'd2); exp_q.push_back(3'd3);
        mask_in = 8'hFF; mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
        chk("unmask_pend", pend, 8'h0F);
        repeat (10) tick();
        chk("unmask_done", raw_pend, 8'h00);

        // Overflow: repeat requests while channel 3 is pending.
        out_ready = 1'b0; req = 8'h08;
        tick();
        chk("ovf_none_first", ovf, 8'h00);
        tick();
        tick();
        req = 8'h00;
        chk("ovf_set", ovf, 8'h08);
        chk("ovf_offer_id", {5'd0, out_id}, 8'h03);
        ovf_clr = 8'h08;
        tick();
        ovf_clr = 8'h00;
        chk("ovf_clr", ovf, 8'h00);

        // Set-wins-over-clear for overflow.
        req = 8'h08; ovf_clr = 8'h08;
        tick();
        req = 8'h00; ovf_clr = 8'h00;
        chk("ovf_set_wins", ovf, 8'h08);
        ovf_clr = 8'h08;
        tick();
        ovf_clr = 8'h00;

        // Request on the accept edge re-pends without overflow.
        exp_q.push_back(3'd3); exp_q.push_back(3'd3);
        out_ready = 1'b1; req = 8'h08;
        tick();
        req = 8'h00;
        chk("coll_raw", raw_pend, 8'h08);
        chk("coll_ovf", ovf, 8'h00);
        chk("coll_valid", {7'd0, out_valid}, 8'h00);
        tick();
        chk("coll_reoffer", {4'd0, out_valid, out_id}, 8'h0B);
        tick();
        chk("coll_done", raw_pend, 8'h00);

        // Reset in the middle of an offer.
        out_ready = 1'b0; req = 8'h10;
        tick();
        req = 8'h00;
        tick();
        chk("mid_offer_id", {4'd0, out_valid, out_id}, 8'h0C);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", {7'd0, out_valid}, 8'h00);
        chk("mid_rst_raw", raw_pend, 8'h00);
        chk("mid_rst_id", {5'd0, out_id}, 8'h00);
        reset = 1'b0;
        tick(); tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL grants_missing: got %0d outstanding expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_collector8.md
Name: irq_collector8

Overview:
- Eight-channel sticky request collector that sits directly upstream of the Or8Way reducer.
- Latches single-cycle request pulses into a pending register and applies a per-channel enable mask.
- Exposes the masked pending vector; an external Or8Way reduces it to a single "any pending" flag.
- Serialises pending channels, lowest index first, through a valid/ready grant handshake.

Parameters:
- MASK_RST, 8'hFF, reset value of the enable mask (1 = channel enabled).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request pulses; bit i high at an edge marks channel i pending.
- mask_we  input  1  load strobe for mask.
- mask_in  input  8  new mask value, written when mask_we = 1.
- pend  output  8  raw_pend & mask; feeds the downstream Or8Way inputs a..h = pend[0..7].
- raw_pend  output  8  unmasked pending register.
- out_valid  output  1  grant offer valid.
- out_id  output  3  channel index being offered.
- out_ready  input  1  consumer accepts the offer.
- ovf  output  8  sticky per-channel overflow: a request arrived while that channel was already pending.
- ovf_clr  input  8  write-1-to-clear for ovf bits.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only at a rising clk edge.
- Reset values:
  - raw_pend = 0, ovf = 0, mask = MASK_RST.
  - out_valid = 0, out_id = 0, FSM = IDLE.
- Reset mid-handshake: reset wins over everything and drops out_valid at the same edge.
- Pending bit i, next value: set if req[i]; else clear if a handshake completes on channel i this edge (out_valid & out_ready & out_id == i); else hold.
  - Set wins over clear at the same edge, so a request coinciding with acceptance re-pends the channel.
- Overflow bit i, next value: set if req[i] & raw_pend[i] & !(accept on channel i this edge); else clear if ovf_clr[i]; else hold.
  - Set wins over clear.
- Mask:
  - Updated at the edge where mask_we = 1; the new value is visible the following cycle.
  - A masked channel still latches pending and ovf but is never offered.
- FSM states: IDLE, OFFER.
  - IDLE: if pend != 0 at the edge, go to OFFER, with out_id = lowest set index of pend and out_valid = 1.
  - OFFER: out_valid and out_id are held stable until out_ready = 1. This holds even if a lower index becomes pending or the offered channel becomes masked meanwhile.
  - OFFER with out_ready = 1 at an edge: clear that pending bit (subject to the set-wins rule), go to IDLE, out_valid = 0.
- Latency:
  - req at edge t: raw_pend/pend visible after t; out_valid high after t+1.
  - Accept at edge a: earliest next offer after edge a+1.
  - Maximum throughput: one grant per 2 cycles.
- out_ready while out_valid = 0 is ignored.
- All outputs are registered or a direct AND of registers (pend); there is no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - FSM state encodings (IDLE = 1'b0, OFFER = 1'b1).
  - Channel count constant N_CH = 8 and id width 3.
- One sub-module: prio_enc8, a combinational lowest-index-first priority encoder (8-bit in → 3-bit id plus any flag).
- The Or8Way reduction stays outside this block.

Test Plan:
- Reset with req = 8'hFF held high → after reset edge, raw_pend = 0, out_valid = 0, mask = 8'hFF, ovf = 0; releasing reset with req = 0 leaves everything idle.
- req = 8'b0010_0100 for one cycle, out_ready = 1 → pend = 8'h24 next cycle; grant id 2, then id 5 two cycles later; pend = 0 afterwards.
- Hold offer: req[6] pulse, out_ready = 0 for 5 cycles, then req[1] pulse → out_id stays 6 until ready; next grant is id 1.
- Mask: mask_in = 8'hF0, mask_we = 1, then req = 8'h0F → raw_pend = 8'h0F, pend = 0, out_valid stays 0; restore mask 8'hFF → grant id 0 follows.
- Overflow and collision:
  - req[3] twice while pending → ovf = 8'h08; ovf_clr = 8'h08 → ovf = 0.
  - req[3] on the accept edge of channel 3 → raw_pend[3] stays 1, ovf[3] stays 0, and channel 3 is offered again.
